// File: rtl/ordinator_pkg.sv
// ordinator_pkg
// Shared constants for the serial expression calculator:
//   - operator word codes (compared against the full input word)
//   - FSM state encoding
package ordinator_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_EQ  = 3'd2;
  localparam logic [OP_W-1:0] OP_AND = 3'd3;
  localparam logic [OP_W-1:0] OP_OR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR = 3'd5;

  // One past the highest legal operator code.
  localparam logic [OP_W-1:0] OP_LIMIT = 3'd6;

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_OPERAND  = 2'd1,
    S_OPERATOR = 2'd2
  } state_t;

endpackage

// File: rtl/ordinator_alu.sv
// ordinator_alu
// Combinational ALU for the calculator accumulator.
// Ports:
//   a   [WIDTH] accumulator value (left operand)
//   b   [WIDTH] incoming operand (right operand)
//   op  [3]     pending operator code
//   y   [WIDTH] result, modulo 2^WIDTH
//   ovf [1]     signed two's-complement overflow (ADD/SUB only)
module ordinator_alu
  import ordinator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  localparam int MSB = WIDTH - 1;

  always_comb begin
    y   = a;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin
        y   = a + b;
        // Same-sign operands producing a result of the other sign.
        ovf = (a[MSB] == b[MSB]) && (y[MSB] != a[MSB]);
      end
      OP_SUB: begin
        y   = a - b;
        // Opposite-sign operands producing a result whose sign left a's.
        ovf = (a[MSB] != b[MSB]) && (y[MSB] != a[MSB]);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      default: begin
        y   = a;
        ovf = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ordinator_param.sv
// ordinator_param
// Serial left-to-right expression calculator with a valid/ready input.
// Words arrive as operand, operator, operand, ..., EQ. After EQ the result
// is latched and the block restarts on its own through one S_INIT cycle.
// Ports:
//   clk      [1]     rising-edge clock
//   reset    [1]     asynchronous active-low reset
//   in       [WIDTH] operand or operator code
//   in_valid [1]     word on in is valid
//   ready    [1]     word accepted this cycle when in_valid is also high
//   result   [WIDTH] last completed expression value
//   done     [1]     one-cycle pulse when result updates
//   overflow [1]     signed overflow seen in the expression on result
//   err      [1]     one-cycle pulse after an invalid operator was consumed
module ordinator_param
  import ordinator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             ready,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             overflow,
  output logic             err
);

  state_t            r_state;
  state_t            w_state_next;
  logic [WIDTH-1:0]  r_acc;
  logic [OP_W-1:0]   r_pend;
  logic              r_ovf_acc;
  logic [WIDTH-1:0]  r_result;
  logic              r_done;
  logic              r_overflow;
  logic              r_err;

  logic              w_ready;
  logic              w_xfer;
  logic              w_is_eq;
  logic              w_op_valid;
  logic [WIDTH-1:0]  w_alu_y;
  logic              w_alu_ovf;

  // Operator decode looks at the whole word, so e.g. 258 is not EQ.
  assign w_is_eq    = (in == WIDTH'(OP_EQ));
  assign w_op_valid = (in < WIDTH'(OP_LIMIT));
  assign w_xfer     = in_valid && w_ready;

  ordinator_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a   (r_acc),
    .b   (in),
    .op  (r_pend),
    .y   (w_alu_y),
    .ovf (w_alu_ovf)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_INIT:     w_state_next = S_OPERAND;
      S_OPERAND:  if (w_xfer) w_state_next = S_OPERATOR;
      S_OPERATOR: begin
        if (w_xfer) begin
          if (w_is_eq)         w_state_next = S_INIT;
          else if (w_op_valid) w_state_next = S_OPERAND;
          else                 w_state_next = S_OPERATOR;
        end
      end
      default:    w_state_next = S_INIT;
    endcase
  end

  // Output logic
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_OPERAND, S_OPERATOR: w_ready = 1'b1;
      default:               w_ready = 1'b0;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc      <= '0;
      r_pend     <= OP_ADD;
      r_ovf_acc  <= 1'b0;
      r_result   <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_INIT: begin
          // First operand then loads as 0 ADD operand.
          r_acc     <= '0;
          r_pend    <= OP_ADD;
          r_ovf_acc <= 1'b0;
        end
        S_OPERAND: begin
          if (w_xfer) begin
            r_acc     <= w_alu_y;
            r_ovf_acc <= r_ovf_acc | w_alu_ovf;
          end
        end
        S_OPERATOR: begin
          if (w_xfer) begin
            if (w_is_eq) begin
              r_result   <= r_acc;
              r_overflow <= r_ovf_acc;
              r_done     <= 1'b1;
            end else if (w_op_valid) begin
              r_pend <= in[OP_W-1:0];
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ready    = w_ready;
  assign result   = r_result;
  assign done     = r_done;
  assign overflow = r_overflow;
  assign err      = r_err;

endmodule

// File: tb/tb_ordinator_param.sv
// tb_ordinator_param
// Directed bench for ordinator_param (WIDTH=8) with hand-computed results.
module tb_ordinator_param;

  logic       clk;
  logic       reset;
  logic [7:0] in;
  logic       in_valid;
  logic       ready;
  logic [7:0] result;
  logic       done;
  logic       overflow;
  logic       err;

  int n_tests;
  int n_fail;
  int done_cnt;
  int err_cnt;
  int ready_low_cnt;
  bit rand_mode;
  bit junk_in_init;

  logic [7:0] vec[$];

  ordinator_param #(
    .WIDTH (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .in_valid (in_valid),
    .ready    (ready),
    .result   (result),
    .done     (done),
    .overflow (overflow),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse and ready-low observers, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (done)   done_cnt++;
      if (err)    err_cnt++;
      if (!ready) ready_low_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, obs);
    end
  endtask

  // Present one word and hold it until it is accepted.
  task automatic send(input logic [7:0] w);
    int n;
    if (rand_mode) begin
      int idle;
      idle = $urandom_range(0, 2);
      for (int i = 0; i < idle; i++) begin
        in       = 8'($urandom_range(0, 255));
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in       = w;
    in_valid = 1'b1;
    n        = 0;
    @(negedge clk);
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Send every word of vec (ending in EQ) and check the outcome.
  task automatic run_expr(input string tag, input int exp_res, input int exp_ovf, input int exp_err);
    int d0;
    int e0;
    d0 = done_cnt;
    e0 = err_cnt;
    foreach (vec[i]) send(vec[i]);
    // Now one edge after the EQ transfer: outputs just updated.
    chk({tag, "_done"},     32'(done),     32'd1);
    chk({tag, "_result"},   32'(result),   32'(exp_res));
    chk({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    if (junk_in_init) begin
      // Block is in S_INIT; this word must be dropped.
      in       = 8'd77;
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_err_pulses"},  32'(err_cnt - e0),  32'(exp_err));
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    done_cnt      = 0;
    err_cnt       = 0;
    ready_low_cnt = 0;
    rand_mode     = 1'b0;
    junk_in_init  = 1'b0;
    reset         = 1'b0;
    in            = 8'd0;
    in_valid      = 1'b0;

    #3;
    chk("rst_result",   32'(result),   32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_err",      32'(err),      32'd0);
    chk("rst_ready",    32'(ready),    32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // 1. single operand
    vec = '{8'd10, 8'd2};
    run_expr("single", 10, 0, 0);

    // 2. add / sub
    vec = '{8'd10, 8'd0, 8'd12, 8'd2};
    run_expr("add", 22, 0, 0);
    vec = '{8'd10, 8'd1, 8'd12, 8'd2};
    run_expr("sub", 254, 0, 0);

    // 3. chain with invalid operators 7, 15, 8
    vec = '{8'd10, 8'd7, 8'd0, 8'd12, 8'd15, 8'd8, 8'd1, 8'd34, 8'd0, 8'd7, 8'd2};
    run_expr("chain", 251, 0, 3);

    // 4. logic ops and overflow
    vec = '{8'd12, 8'd4, 8'd3, 8'd5, 8'd5, 8'd2};
    run_expr("logic", 10, 0, 0);
    vec = '{8'd100, 8'd0, 8'd100, 8'd2};
    run_expr("ovf", 200, 1, 0);
    vec = '{8'd3, 8'd3, 8'd6, 8'd2};
    run_expr("and", 2, 0, 0);

    // 5. handshake: random idle gaps and junk during S_INIT
    rand_mode     = 1'b1;
    junk_in_init  = 1'b1;
    ready_low_cnt = 0;
    vec = '{8'd10, 8'd0, 8'd12, 8'd2};
    run_expr("hs1", 22, 0, 0);
    vec = '{8'd10, 8'd0, 8'd12, 8'd2};
    run_expr("hs2", 22, 0, 0);
    chk("hs_ready_low", 32'(ready_low_cnt), 32'd2);
    rand_mode    = 1'b0;
    junk_in_init = 1'b0;

    // 6. async reset mid-expression
    send(8'd10);
    send(8'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_result", 32'(result), 32'd0);
    chk("arst_ready",  32'(ready),  32'd0);
    chk("arst_done",   32'(done),   32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    vec = '{8'd5, 8'd2};
    run_expr("after_rst", 5, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ordinator_param.md
Name: ordinator_param

Overview:
Parametrised successor of the 8-bit serial calculator. Accepts a stream of words on one input bus: operand, operator, operand, ..., then EQ. Accumulates left to right, with no precedence, and presents the result.
Adds an in_valid/ready handshake, WIDTH generalisation, logic operators, a sticky signed-overflow flag, an invalid-operator error pulse and automatic restart after EQ. Sits between the input front-end (switch/debounce logic) and the 7-segment display driver.

Parameters:
WIDTH, 8, data/accumulator width in bits; legal range 3..32.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset
in  input  WIDTH  operand or operator code, depending on state
in_valid  input  1  word on in is valid
ready  output  1  block accepts a word this cycle; transfer = in_valid & ready
result  output  WIDTH  last completed expression value, two's complement
done  output  1  one-cycle pulse, the cycle result updates
overflow  output  1  signed overflow occurred in the expression now shown on result
err  output  1  one-cycle pulse, an invalid operator was consumed

Behaviour:
- Reset (reset=0, asynchronous):
  - state=S_INIT; acc=0; pend=OP_ADD; ovf_acc=0.
  - result=0, done=0, overflow=0, err=0, ready=0.
  - Reset asserted mid-expression discards everything, including a result not yet latched.
- Operator codes compare the full WIDTH-bit word: 0 ADD, 1 SUB, 2 EQ, 3 AND, 4 OR, 5 XOR. Any other value is invalid.
- States:
  - S_INIT: ready=0 for exactly one cycle. Clears acc=0, pend=ADD, ovf_acc=0. Next state S_OPERAND.
  - S_OPERAND: ready=1. On transfer: acc <= alu(acc, in, pend); ovf_acc <= ovf_acc | alu_ovf; next state S_OPERATOR. The first operand therefore loads via 0 ADD in.
  - S_OPERATOR: ready=1. On transfer:
    - EQ: result <= acc; overflow <= ovf_acc; done=1 next cycle; go to S_INIT (auto restart).
    - valid non-EQ code: pend <= in; go to S_OPERAND.
    - invalid code: err=1 next cycle; stay in S_OPERATOR; acc and pend unchanged.
- in_valid while ready=0 is ignored: the word is dropped and no err is raised.
- Latency: result, overflow and done update on the clock edge one cycle after the EQ transfer. The next expression's first operand can transfer 2 cycles after the EQ transfer.
- result and overflow hold their values until the next EQ transfer or reset. done and err are registered single-cycle pulses.
- Arithmetic:
  - All results are modulo 2^WIDTH.
  - ADD/SUB set alu_ovf on signed two's-complement overflow: operand signs agree (ADD) or differ (SUB), and the result sign differs from acc.
  - AND/OR/XOR never set alu_ovf.
  - ovf_acc is sticky within one expression and cleared in S_INIT.
- Ready and in_valid asserted in the same cycle as reset deassertion: no transfer, because the block is in S_INIT.

Decomposition:
- Package ordinator_pkg:
  - operator code constants OP_ADD..OP_XOR.
  - state encoding constants S_INIT, S_OPERAND, S_OPERATOR.
- Sub-module ordinator_alu:
  - combinational, parametrised by WIDTH.
  - inputs: a, b, op. Outputs: y, ovf.
  - instantiated once; the FSM, acc, pend and output registers stay in ordinator_param.

Test Plan:
All scenarios run with WIDTH=8.
1. Single operand: transfer 10, then EQ -> result=10, done pulses once one cycle after EQ, overflow=0, err=0.
2. Basic add/sub:
   - 10 ADD 12 EQ -> result=22.
   - After auto restart, 10 SUB 12 EQ -> result=254, overflow=0.
3. Chain with invalid ops: 10, 7, 0, 12, 15, 8, 1, 34, 0, 7, EQ -> result=251. err pulses exactly 3 times; the operator words 7, 15 and 8 are ignored.
4. Logic and overflow:
   - 12 OR 3 XOR 5 EQ -> result=10, overflow=0.
   - 100 ADD 100 EQ -> result=200, overflow=1.
   - 3 AND 6 EQ -> result=2, overflow=0 (sticky flag cleared by restart).
5. Handshake: toggle in_valid randomly, and drive words during S_INIT cycles -> words with ready=0 are dropped. Chain 10 ADD 12 EQ still yields 22, and the ready low-cycle count equals the expression count.
6. Async reset mid-expression:
   - Transfer 10 ADD, then pull reset low between clock edges -> result=0, ready=0 and done=0 immediately, before the next clk edge.
   - After release, 5 EQ -> result=5.
